// File: rtl/axil_sram_pkg.sv
// Shared definitions for the AXI-Lite SRAM responder.
// Contents: the AXI response codes, the write and read FSM state enums, and
// the data word returned by an out-of-range read when the error option
// (AXIL_SRAM_SLVERR_EN) is enabled.
package axil_sram_pkg;

  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR_OK,
    W_DATA_OK,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite link between the JTAG-AXI bridge (master) and a responder (slave).
// Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH.
// Modports: master drives AW/W/AR and the B/R readies; slave drives the rest.
interface AXI_LITE #(
  parameter int AXI_ADDR_WIDTH = 17,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/axil_sram_mem.sv
// Word-wide storage for the AXI-Lite SRAM responder.
// Ports:
//   clk_i            rising-edge clock
//   we_i, be_i       write enable and per-byte lane enables
//   waddr_i, wdata_i write word index and data
//   re_i, raddr_i    read enable and word index
//   rdata_o          registered read data; holds its value while re_i is low
// A read and a write to the same word on one edge return the old contents.
// Storage is never reset.
module axil_sram_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [IW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int n = 0; n < 4; n++) begin
        if (be_i[n]) mem_q[waddr_i][8*n +: 8] <= wdata_i[8*n +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_sram_slave.sv
// AXI-Lite SRAM responder on the JTAG-AXI bridge link.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset (storage contents survive it)
//   axilite  AXI_LITE slave modport, 17-bit address, 32-bit data
// Build option: AXIL_SRAM_SLVERR_EN turns out-of-range accesses into SLVERR
// responses (write dropped, read returns ERR_DATA); without it the word index
// wraps modulo DEPTH and every response is OKAY.
//
// Write FSM
//   state     | meaning
//   W_IDLE    | nothing captured
//   W_ADDR_OK | AW captured, waiting for W
//   W_DATA_OK | W captured, waiting for AW
//   W_RESP    | memory updated, B pending
// Read FSM
//   R_IDLE    | ready for AR
//   R_RESP    | R pending
module axil_sram_slave
  import axil_sram_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [16:0] BASE_ADDR = 17'h0
) (
  input  logic   clk_i,
  input  logic   rst_i,
  AXI_LITE.slave axilite
);

  localparam int unsigned IW = $clog2(DEPTH);

  wr_state_e     wr_state_q, wr_state_d;
  rd_state_e     rd_state_q, rd_state_d;
  logic [IW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          wok_q, wok_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rok_q, rok_d;

  logic [16:0]   aw_off, ar_off;
  logic          aw_ok, ar_ok;
  logic          aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, ar_hs;
  logic          commit, commit_ok, mem_we;
  logic [IW-1:0] mem_waddr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
  logic          unused_bits;

  // Below-base addresses wrap to large offsets and so fall out of range.
  assign aw_off = axilite.awaddr - BASE_ADDR;
  assign ar_off = axilite.araddr - BASE_ADDR;

`ifdef AXIL_SRAM_SLVERR_EN
  localparam logic [16:0] SPAN = 17'(DEPTH * 4);
  assign aw_ok = (aw_off < SPAN);
  assign ar_ok = (ar_off < SPAN);
  assign unused_bits = ^{axilite.awprot, axilite.arprot, aw_off[1:0], ar_off[1:0]};
`else
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
  assign unused_bits = ^{axilite.awprot, axilite.arprot, aw_off[1:0], ar_off[1:0],
                         aw_off[16:IW+2], ar_off[16:IW+2]};
`endif

  // Readies are masked during reset so nothing is accepted on a reset edge.
  assign aw_rdy = !rst_i && (wr_state_q == W_IDLE || wr_state_q == W_DATA_OK);
  assign w_rdy  = !rst_i && (wr_state_q == W_IDLE || wr_state_q == W_ADDR_OK);
  assign ar_rdy = !rst_i && (rd_state_q == R_IDLE);
  assign aw_hs  = axilite.awvalid && aw_rdy;
  assign w_hs   = axilite.wvalid && w_rdy;
  assign ar_hs  = axilite.arvalid && ar_rdy;

  always_comb begin
    wr_state_d = wr_state_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wok_d      = wok_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    commit_ok  = wok_q;
    mem_waddr  = waddr_q;
    mem_wdata  = wdata_q;
    mem_wstrb  = wstrb_q;

    // The live channel beats go straight to memory when they complete the pair.
    if (aw_hs) begin
      waddr_d   = aw_off[IW+1:2];
      wok_d     = aw_ok;
      mem_waddr = aw_off[IW+1:2];
      commit_ok = aw_ok;
    end
    if (w_hs) begin
      wdata_d   = axilite.wdata;
      wstrb_d   = axilite.wstrb;
      mem_wdata = axilite.wdata;
      mem_wstrb = axilite.wstrb;
    end

    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end else if (aw_hs) begin
          wr_state_d = W_ADDR_OK;
        end else if (w_hs) begin
          wr_state_d = W_DATA_OK;
        end
      end
      W_ADDR_OK: if (w_hs) begin
        commit     = 1'b1;
        wr_state_d = W_RESP;
      end
      W_DATA_OK: if (aw_hs) begin
        commit     = 1'b1;
        wr_state_d = W_RESP;
      end
      W_RESP: if (axilite.bready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase

    if (commit) bresp_d = commit_ok ? OKAY : SLVERR;
    mem_we = commit && commit_ok;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rok_d      = rok_q;
    case (rd_state_q)
      R_IDLE: if (ar_hs) begin
        rd_state_d = R_RESP;
        rok_d      = ar_ok;
      end
      R_RESP: if (axilite.rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wok_q      <= 1'b0;
      bresp_q    <= OKAY;
      rok_q      <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wok_q      <= wok_d;
      bresp_q    <= bresp_d;
      rok_q      <= rok_d;
    end
  end

  axil_sram_mem #(.DEPTH(DEPTH), .IW(IW)) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .be_i    (mem_wstrb),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (ar_hs),
    .raddr_i (ar_off[IW+1:2]),
    .rdata_o (mem_rdata)
  );

  assign axilite.awready = aw_rdy;
  assign axilite.wready  = w_rdy;
  assign axilite.arready = ar_rdy;
  assign axilite.bvalid  = (wr_state_q == W_RESP);
  assign axilite.bresp   = bresp_q;
  assign axilite.rvalid  = (rd_state_q == R_RESP);
  assign axilite.rresp   = (rd_state_q == R_RESP && !rok_q) ? SLVERR : OKAY;
  // rdata is forced to zero outside a response so reset leaves it clean.
  assign axilite.rdata   = (rd_state_q != R_RESP) ? 32'h0 :
                           (rok_q ? mem_rdata : ERR_DATA);

endmodule

// File: doc/axil_sram_slave.md
AXIL_SRAM_SLAVE -- requirements
Module: axil_sram_slave

Interface
REQ-001 Parameter DEPTH, default 256, meaning the number of 32-bit storage words (power of two, 4..4096).
REQ-002 Parameter BASE_ADDR, default 17'h0, meaning the byte address of word 0 (DEPTH*4-aligned).
REQ-003 Port clk_i  input  1  single clock; all logic is rising-edge.
REQ-004 Port rst_i  input  1  reset, synchronous, active-high.
REQ-005 Port axilite  slave modport  AXI_LITE #(AXI_ADDR_WIDTH=17, AXI_DATA_WIDTH=32)  responder end of the JTAG-AXI bridge link.

Function
REQ-006 The block SHALL decode the word index as (addr - BASE_ADDR)[16:2] and ignore addr[1:0] and the prot fields.
REQ-007 An address SHALL be in range iff 0 <= (addr - BASE_ADDR) < DEPTH*4, using unsigned 17-bit arithmetic (below-base addresses wrap large, hence out of range).
REQ-008 Write FSM states: W_IDLE, W_ADDR_OK (AW captured), W_DATA_OK (W captured), W_RESP.
REQ-009 awready SHALL be high only when AW is not yet captured and no B is pending; wready SHALL be high only when W is not yet captured and no B is pending.
REQ-010 AW and W SHALL be accepted in either order or in the same cycle; the memory update SHALL occur on the edge where the second of the two is captured.
REQ-011 bvalid SHALL rise in the cycle after both AW and W are captured and SHALL hold with a stable bresp until bready is sampled high, then return to W_IDLE.
REQ-012 Byte lane n SHALL be written only when wstrb[n]=1; wstrb=4'h0 SHALL leave memory unchanged and return OKAY.
REQ-013 Read FSM states: R_IDLE, R_RESP; arready SHALL be high in R_IDLE only.
REQ-014 rvalid SHALL rise in the cycle after the AR handshake (1-cycle latency), with rdata and rresp held stable until rready is sampled high.
REQ-015 A read accepted in the same cycle as a write commit to the same word SHALL return the pre-write data.
REQ-016 The read and write channels SHALL operate independently; neither SHALL stall the other.
REQ-017 bvalid/rvalid SHALL never be deasserted without a ready handshake, and back-to-back transactions SHALL sustain one write per 2 cycles and one read per 2 cycles.

Reset
REQ-018 While rst_i=1: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 32'h0; both FSMs are in IDLE.
REQ-019 awready, wready and arready SHALL assert in the first cycle after rst_i falls.
REQ-020 A reset asserted mid-transaction SHALL discard captured AW/W/AR and pending B/R without emitting a response; memory contents SHALL NOT be reset.

Configuration
REQ-021 With AXIL_SRAM_SLVERR_EN defined, an out-of-range write SHALL not modify memory and SHALL return bresp=SLVERR, and an out-of-range read SHALL return rresp=SLVERR with rdata=32'hDEADBEEF.
REQ-022 Without AXIL_SRAM_SLVERR_EN, the word index SHALL wrap modulo DEPTH and all responses SHALL be OKAY.

Structure
REQ-023 Package axil_sram_pkg SHALL hold the resp codes (OKAY=2'b00, SLVERR=2'b10), the wr_state_e/rd_state_e enums and the ERR_DATA constant 32'hDEADBEEF.
REQ-024 Storage SHALL be a sub-module axil_sram_mem (one write port with 4 byte enables, one registered read port); the FSMs live in axil_sram_slave.

Verification
REQ-025 Write 0x10 <- 32'hCAFEF00D (strb 4'hF), then read 0x10 -> bresp OKAY; rdata 32'hCAFEF00D, rvalid exactly 1 cycle after AR handshake.
REQ-026 W presented 3 cycles before AW, then AW with addr 0x20 -> wready drops after W, bvalid rises 1 cycle after AW handshake; readback is correct.
REQ-027 Preload 0x04 = 32'h11223344, write 32'hAABBCCDD with strb 4'b0101 -> readback 32'h11BB33DD.
REQ-028 Hold bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout; a read to 0x00 still completes meanwhile.
REQ-029 With DEPTH=256, read 0x400: SLVERR_EN defined -> rresp SLVERR, rdata 32'hDEADBEEF; undefined -> OKAY, data of word 0.
REQ-030 Assert rst_i while bvalid=1 -> bvalid=0 on the next edge, readies high 1 cycle after release, previously written data retained.
